// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits and a sequential clear engine.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Ld_REG,
  input  logic [ADDR_W-1:0] DR,
  input  logic [DATA_W-1:0] In,
  input  logic [ADDR_W-1:0] SR1_ADDR,
  input  logic [ADDR_W-1:0] SR2_ADDR,
  output logic [DATA_W-1:0] SR1,
  output logic [DATA_W-1:0] SR2,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] Reserve_DR,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              Clear_req,
  output logic              Clear_busy
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      pending    <= '0;
      state      <= IDLE;
      idx        <= '0;
      Clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Ld_REG) begin
            regs[DR]    <= In;
            pending[DR] <= 1'b0;
          end
          // Reserve is assigned after the write so it wins on a same-register collision.
          if (Reserve) pending[Reserve_DR] <= 1'b1;
          if (Clear_req) begin
            state      <= CLEAR;
            idx        <= '0;
            Clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          regs[idx]    <= '0;
          pending[idx] <= 1'b0;
          idx          <= idx + ADDR_W'(1);
          if (idx == LAST_IDX) begin
            state      <= IDLE;
            Clear_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          Clear_busy <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    SR1   = regs[SR1_ADDR];
    SR2   = regs[SR2_ADDR];
    Busy1 = pending[SR1_ADDR];
    Busy2 = pending[SR2_ADDR];
    if (BYPASS && Ld_REG && !Clear_busy) begin
      if (DR == SR1_ADDR) begin
        SR1   = In;
        Busy1 = Reserve && (Reserve_DR == SR1_ADDR);
      end
      if (DR == SR2_ADDR) begin
        SR2   = In;
        Busy2 = Reserve && (Reserve_DR == SR2_ADDR);
      end
    end
  end

endmodule
